// File: rtl/spectrum_peak_hold_pkg.sv
// Shared FFT project defaults used by the spectrum peak-hold block and its RAM.
package spectrum_peak_hold_pkg;

    // log2 of FFT points (N); bin index width
    localparam int DEFAULT_BW_FFTP  = 9;
    // signed width of each real/imaginary input sample
    localparam int DEFAULT_BW_DATA  = 16;
    // peak decay: peak -= peak >> DEFAULT_DECAY_SH per frame
    localparam int DEFAULT_DECAY_SH = 4;

endpackage

// File: rtl/spectrum_peak_hold_peak_ram.sv
// Simple dual-port peak storage, one entry per positive-frequency bin.
// Synchronous one-cycle read; both ports frozen while en is low.
module spectrum_peak_hold_peak_ram
    import spectrum_peak_hold_pkg::*;
#(
    parameter int AW = DEFAULT_BW_FFTP - 1,
    parameter int DW = 2 * DEFAULT_BW_DATA
) (
    input  logic          clk,
    input  logic          en,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    // Registered read and write; contents are never reset
    always_ff @(posedge clk) begin
        if (en) begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/spectrum_peak_hold.sv
// Spectrum power and peak-hold with decay for the first half of each FFT frame.
// Pipeline: S1 input capture/bin index, S2 power, S3 peak read, output+write.
module spectrum_peak_hold
    import spectrum_peak_hold_pkg::*;
#(
    parameter int bw_fftp  = DEFAULT_BW_FFTP,
    parameter int bw_data  = DEFAULT_BW_DATA,
    parameter int DECAY_SH = DEFAULT_DECAY_SH
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   ClockEn,
    input  logic                   InValid,
    input  logic                   InFirst,
    input  logic [bw_data-1:0]     InRe,
    input  logic [bw_data-1:0]     InIm,
    output logic                   OutValid,
    output logic [bw_fftp-2:0]     OutBin,
    output logic [2*bw_data-1:0]   OutPower,
    output logic [2*bw_data-1:0]   OutPeak,
    output logic                   FrameDone
);

    localparam int PW = 2 * bw_data;
    localparam int AW = bw_fftp - 1;
    localparam logic [bw_fftp-1:0] LAST_HALF = bw_fftp'((1 << (bw_fftp - 1)) - 1);

    logic [bw_fftp-1:0] cnt_reg;
    logic [bw_fftp-1:0] cur_bin;
    logic               contig_reg;
    logic               contig_eff;
    logic               is_half;
    logic               is_last;
    logic               first_frame_reg;

    logic               v1_reg, done1_reg;
    logic [AW-1:0]      bin1_reg;
    logic [bw_data-1:0] re1_reg, im1_reg;

    logic               v2_reg, done2_reg;
    logic [AW-1:0]      bin2_reg;
    logic [PW-1:0]      power2_reg;

    logic               v3_reg, done3_reg;
    logic [AW-1:0]      bin3_reg;
    logic [PW-1:0]      power3_reg;

    logic signed [PW-1:0] re_ext, im_ext;
    logic [PW-1:0]      power_c;
    logic [PW-1:0]      ram_rd;
    logic [PW-1:0]      peak_old;
    logic [PW-1:0]      peak_new;
    logic               ram_we;

    // Index of the incoming bin; a frame only completes if it started with InFirst
    always_comb begin
        cur_bin    = InFirst ? '0 : cnt_reg + bw_fftp'(1);
        contig_eff = InFirst | contig_reg;
        is_half    = ~cur_bin[bw_fftp-1];
        is_last    = (cur_bin == LAST_HALF);
    end

    // S1: bin counter, contiguity tracking and input capture
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_reg    <= '0;
            contig_reg <= 1'b0;
            v1_reg     <= 1'b0;
            done1_reg  <= 1'b0;
        end else if (ClockEn) begin
            v1_reg    <= InValid & is_half;
            done1_reg <= InValid & is_last & contig_eff;
            if (InValid) begin
                cnt_reg    <= cur_bin;
                // one FrameDone per InFirst: close the frame once its last bin is seen
                contig_reg <= contig_eff & ~is_last;
            end
            bin1_reg <= cur_bin[AW-1:0];
            re1_reg  <= InRe;
            im1_reg  <= InIm;
        end
    end

    // Full-width power; the largest value 2^(PW-1) still fits unsigned
    always_comb begin
        re_ext  = {{bw_data{re1_reg[bw_data-1]}}, re1_reg};
        im_ext  = {{bw_data{im1_reg[bw_data-1]}}, im1_reg};
        power_c = $unsigned(re_ext * re_ext) + $unsigned(im_ext * im_ext);
    end

    // S2 and S3: carry power/bin alongside the peak RAM read issued from S2
    always_ff @(posedge Clock) begin
        if (Reset) begin
            v2_reg    <= 1'b0;
            done2_reg <= 1'b0;
            v3_reg    <= 1'b0;
            done3_reg <= 1'b0;
        end else if (ClockEn) begin
            v2_reg     <= v1_reg;
            done2_reg  <= done1_reg;
            bin2_reg   <= bin1_reg;
            power2_reg <= power_c;
            v3_reg     <= v2_reg;
            done3_reg  <= done2_reg;
            bin3_reg   <= bin2_reg;
            power3_reg <= power2_reg;
        end
    end

    // Peak update; stale memory is masked until the first frame has completed
    always_comb begin
        peak_old = first_frame_reg ? '0 : ram_rd;
        if (power3_reg >= peak_old) begin
            peak_new = power3_reg;
        end else begin
            peak_new = peak_old - (peak_old >> DECAY_SH);
        end
        ram_we = ClockEn & v3_reg & ~Reset;
    end

    // Output stage and first-frame flag
    always_ff @(posedge Clock) begin
        if (Reset) begin
            OutValid        <= 1'b0;
            FrameDone       <= 1'b0;
            OutBin          <= '0;
            OutPower        <= '0;
            OutPeak         <= '0;
            first_frame_reg <= 1'b1;
        end else if (ClockEn) begin
            OutValid  <= v3_reg;
            FrameDone <= v3_reg & done3_reg;
            if (v3_reg) begin
                OutBin   <= bin3_reg;
                OutPower <= power3_reg;
                OutPeak  <= peak_new;
            end
            if (v3_reg & done3_reg) begin
                first_frame_reg <= 1'b0;
            end
        end
    end

    spectrum_peak_hold_peak_ram #(
        .AW(AW),
        .DW(PW)
    ) peak_ram (
        .clk    (Clock),
        .en     (ClockEn),
        .wr_en  (ram_we),
        .wr_addr(bin3_reg),
        .wr_data(peak_new),
        .rd_addr(bin2_reg),
        .rd_data(ram_rd)
    );

endmodule

// File: doc/spectrum_peak_hold.md
SPECTRUM_PEAK_HOLD -- requirements
Module: spectrum_peak_hold

Interface
REQ-001 SHALL have parameter bw_fftp, default 9: log2 of FFT points N; bin index width.
REQ-002 SHALL have parameter bw_data, default 16: signed width of the real and imaginary inputs.
REQ-003 SHALL have parameter DECAY_SH, default 4: peak decay shift.
REQ-004 SHALL have ports as listed; one clock; reset is synchronous and active-high:
- Clock  in  1  sole clock, rising edge.
- Reset  in  1  synchronous, active-high.
- ClockEn  in  1  pipeline advance enable.
- InValid  in  1  bin present on InRe/InIm.
- InFirst  in  1  marks bin 0 of a frame; qualified by InValid.
- InRe  in  bw_data  signed real part, natural (bit-reverse-corrected) order.
- InIm  in  bw_data  signed imaginary part.
- OutValid  out  1  output bin valid.
- OutBin  out  bw_fftp-1  output bin index.
- OutPower  out  2*bw_data  unsigned Re^2+Im^2.
- OutPeak  out  2*bw_data  unsigned held/decayed peak.
- FrameDone  out  1  one-cycle pulse coincident with last output bin.

Function
REQ-005 SHALL keep a bin counter: on InValid&InFirst it loads 0; on InValid without InFirst it increments, wrapping from N-1 to 0.
REQ-006 SHALL pass only bins 0..N/2-1 to the outputs; bins N/2..N-1 are consumed and dropped (OutValid stays 0).
REQ-007 SHALL compute power = Re*Re + Im*Im at full 2*bw_data width, unsigned, no saturation (max 2^(2*bw_data-1) fits).
REQ-008 SHALL read the stored peak for the bin and form peak_new = power when power >= peak_old, else peak_old - (peak_old >> DECAY_SH).
REQ-009 SHALL write peak_new back to the same bin address and present it on OutPeak.
REQ-010 SHALL have latency exactly 3 enabled cycles: input accepted at enabled edge k appears on outputs after enabled edge k+3.
REQ-011 SHALL treat ClockEn=0 as a full freeze: no register, counter, or memory write changes; outputs hold.
REQ-012 SHALL pulse FrameDone with OutValid for bin N/2-1 only if bins 0..N/2-1 arrived contiguously since the last InFirst.
REQ-013 SHALL abort the current frame when InFirst arrives mid-frame: counter restarts at 0, no FrameDone for the aborted frame, bins already in the pipeline still complete.
REQ-014 SHALL maintain a first-frame flag: while set, peak_old is taken as 0 (memory content ignored); it clears on the first FrameDone.
REQ-015 SHALL hold peak 0 at 0 under decay; decay never underflows.

Reset
REQ-016 SHALL on Reset clear OutValid, FrameDone, OutBin, OutPower, OutPeak, bin counter and pipeline valids to 0, and set the first-frame flag; Reset overrides ClockEn.
REQ-017 SHALL NOT clear peak memory on Reset; REQ-014 makes stale contents invisible.
REQ-018 SHALL on Reset mid-frame discard all in-flight bins (OutValid 0 after that edge).

Structure
REQ-019 SHALL take bw_fftp, bw_data and DECAY_SH defaults from the shared project package/include used by the FFT stages.
REQ-020 SHALL implement peak storage as sub-module peak_ram: simple dual-port, N/2 x 2*bw_data, synchronous 1-cycle read, write in stage 3; no same-address hazard because bins are sequential.

Verification (bw_fftp=4, bw_data=16, DECAY_SH=2)
REQ-021 SHALL cover: Reset, frame of 16 bins Re=3 Im=4 -> OutBin 0..7, OutPower=25, OutPeak=25, latency 3, FrameDone at bin 7.
REQ-022 SHALL cover: two following frames Re=Im=0 -> OutPeak 19 then 15 for every bin, OutPower=0.
REQ-023 SHALL cover: Re=Im=-32768 -> OutPower=0x80000000, OutPeak=0x80000000.
REQ-024 SHALL cover: ClockEn low 5 cycles mid-frame -> outputs frozen, bins 0..7 each emitted exactly once.
REQ-025 SHALL cover: InFirst at bin 5 -> restart at 0, no FrameDone for the aborted frame; Reset mid-frame -> OutValid 0 next cycle and next frame gives OutPeak=OutPower.
